// File: rtl/cache_ctrl.sv
// Per-request sequencer for the 4-way L1 tag/compare datapath: array read,
// compare, optional writeback, line fill, then tag/valid/mod/PLRU update.
module cache_ctrl #(
  parameter int TAG_WIDTH = 14,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pe_req,
  input  logic                 pe_wr,
  input  logic [TAG_WIDTH-1:0] pe_tag,
  output logic                 pe_ready,
  output logic                 pe_done,
  output logic                 pe_hit,
  output logic                 arr_rd,
  output logic                 pe_access,
  output logic [TAG_WIDTH-1:0] pe_tag_q,
  input  logic [3:0]           way_hit,
  input  logic [3:0]           fill_or_victim_way,
  input  logic                 req_clean,
  input  logic [2:0]           lru_in,
  output logic [2:0]           lru_wdata,
  output logic                 lru_we,
  output logic [3:0]           way_sel,
  output logic                 tag_we,
  output logic                 val_we,
  output logic                 mod_we,
  output logic                 mod_wdata,
  output logic                 mem_wr_req,
  output logic                 mem_rd_req,
  input  logic                 mem_ack,
  output logic                 err_multi_hit,
  output logic [CNT_WIDTH-1:0] hit_cnt,
  output logic [CNT_WIDTH-1:0] miss_cnt,
  output logic [CNT_WIDTH-1:0] wb_cnt
);

  typedef enum logic [2:0] {IDLE, READ, CMP, WB, FILL, UPD} state_t;

  state_t     state, state_next;
  logic       wr_q;
  logic       hit_q;
  logic [3:0] way_q;
  logic [3:0] hit_low;
  logic       any_hit;
  logic       multi_hit;
  logic [2:0] plru_next;

  // Isolate the lowest-index set bit so a corrupted multi-hit still picks one way.
  assign any_hit   = |way_hit;
  assign hit_low   = way_hit & (~way_hit + 4'd1);
  assign multi_hit = (way_hit & (way_hit - 4'd1)) != 4'd0;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q          <= 1'b0;
      hit_q         <= 1'b0;
      way_q         <= 4'd0;
      pe_tag_q      <= '0;
      err_multi_hit <= 1'b0;
      hit_cnt       <= '0;
      miss_cnt      <= '0;
      wb_cnt        <= '0;
    end else begin
      if (state == IDLE && pe_req) begin
        wr_q     <= pe_wr;
        pe_tag_q <= pe_tag;
      end
      if (state == CMP) begin
        hit_q <= any_hit;
        if (any_hit) begin
          way_q   <= hit_low;
          hit_cnt <= sat_inc(hit_cnt);
          if (multi_hit) err_multi_hit <= 1'b1;
        end else begin
          way_q    <= fill_or_victim_way;
          miss_cnt <= sat_inc(miss_cnt);
        end
      end
      if (state == WB && mem_ack) wb_cnt <= sat_inc(wb_cnt);
    end
  end

  // Tree PLRU: bit 2 picks the half, bits 1/0 pick within it; point away from the accessed way.
  always_comb begin
    plru_next = lru_in;
    case (way_q)
      4'b1000: plru_next = {1'b1, 1'b1, lru_in[0]};
      4'b0100: plru_next = {1'b1, 1'b0, lru_in[0]};
      4'b0010: plru_next = {1'b0, lru_in[1], 1'b1};
      4'b0001: plru_next = {1'b0, lru_in[1], 1'b0};
      default: plru_next = lru_in;
    endcase
  end

  always_comb begin
    state_next = state;
    pe_ready   = 1'b0;
    pe_done    = 1'b0;
    pe_hit     = 1'b0;
    arr_rd     = 1'b0;
    pe_access  = 1'b0;
    lru_wdata  = 3'd0;
    lru_we     = 1'b0;
    way_sel    = 4'd0;
    tag_we     = 1'b0;
    val_we     = 1'b0;
    mod_we     = 1'b0;
    mod_wdata  = 1'b0;
    mem_wr_req = 1'b0;
    mem_rd_req = 1'b0;
    case (state)
      IDLE: begin
        pe_ready = rst_n;
        if (pe_req) state_next = READ;
      end
      READ: begin
        arr_rd     = 1'b1;
        state_next = CMP;
      end
      CMP: begin
        pe_access = 1'b1;
        if (any_hit)        state_next = UPD;
        else if (req_clean) state_next = FILL;
        else                state_next = WB;
      end
      WB: begin
        mem_wr_req = 1'b1;
        if (mem_ack) state_next = FILL;
      end
      FILL: begin
        mem_rd_req = 1'b1;
        if (mem_ack) begin
          tag_we     = 1'b1;
          val_we     = 1'b1;
          way_sel    = way_q;
          state_next = UPD;
        end
      end
      UPD: begin
        lru_we     = 1'b1;
        lru_wdata  = plru_next;
        way_sel    = way_q;
        // A read miss clears mod for the freshly filled line; a read hit leaves it alone.
        mod_we     = wr_q | ~hit_q;
        mod_wdata  = wr_q;
        pe_done    = 1'b1;
        pe_hit     = hit_q;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// Randomized bench for cache_ctrl: a transaction-level model predicts way choice,
// PLRU write data, mod write, latency and saturating statistics.
module tb_cache_ctrl;
  localparam int TW  = 14;
  localparam int CW  = 4;
  localparam int SAT = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          pe_req, pe_wr;
  logic [TW-1:0] pe_tag;
  logic          pe_ready, pe_done, pe_hit, arr_rd, pe_access;
  logic [TW-1:0] pe_tag_q;
  logic [3:0]    way_hit, fill_or_victim_way;
  logic          req_clean;
  logic [2:0]    lru_in, lru_wdata;
  logic          lru_we;
  logic [3:0]    way_sel;
  logic          tag_we, val_we, mod_we, mod_wdata;
  logic          mem_wr_req, mem_rd_req, mem_ack;
  logic          err_multi_hit;
  logic [CW-1:0] hit_cnt, miss_cnt, wb_cnt;

  int checks = 0;
  int errors = 0;
  int txn_no = 0;
  int m_hits = 0, m_miss = 0, m_wb = 0;
  logic m_err = 1'b0;

  cache_ctrl #(.TAG_WIDTH(TW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .pe_req(pe_req), .pe_wr(pe_wr), .pe_tag(pe_tag),
    .pe_ready(pe_ready), .pe_done(pe_done), .pe_hit(pe_hit), .arr_rd(arr_rd),
    .pe_access(pe_access), .pe_tag_q(pe_tag_q), .way_hit(way_hit),
    .fill_or_victim_way(fill_or_victim_way), .req_clean(req_clean), .lru_in(lru_in),
    .lru_wdata(lru_wdata), .lru_we(lru_we), .way_sel(way_sel), .tag_we(tag_we),
    .val_we(val_we), .mod_we(mod_we), .mod_wdata(mod_wdata), .mem_wr_req(mem_wr_req),
    .mem_rd_req(mem_rd_req), .mem_ack(mem_ack), .err_multi_hit(err_multi_hit),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (txn %0d)", name, got, exp, txn_no);
    end
  endtask

  task automatic check_stats();
    check("hit_cnt", 32'(hit_cnt), m_hits);
    check("miss_cnt", 32'(miss_cnt), m_miss);
    check("wb_cnt", 32'(wb_cnt), m_wb);
    check("err_multi_hit", 32'(err_multi_hit), 32'(m_err));
  endtask

  task automatic do_txn(input logic w, input logic [TW-1:0] t, input logic [3:0] wh,
                        input logic [3:0] vic, input logic cl, input logic [2:0] lr,
                        input int dwb, input int dfl);
    int idx, elat, n, wbc, flc, tagc, arr_n, acc_n;
    logic eh, ewb;
    logic [3:0] ew;
    logic [2:0] elru;
    bit done;
    idx = 0; n = 0; wbc = 0; flc = 0; tagc = 0; arr_n = -1; acc_n = -1; done = 0;
    txn_no++;
    eh = (wh != 4'd0);
    if (eh) begin
      for (int i = 3; i >= 0; i--) if (wh[i]) idx = i;
      if ($countones(wh) > 1) m_err = 1'b1;
      if (m_hits < SAT) m_hits++;
    end else begin
      for (int i = 0; i < 4; i++) if (vic[i]) idx = i;
      if (m_miss < SAT) m_miss++;
    end
    ewb = !eh && !cl;
    if (ewb && m_wb < SAT) m_wb++;
    ew = 4'b0001 << idx;
    case (idx)
      3:       elru = {2'b11, lr[0]};
      2:       elru = {2'b10, lr[0]};
      1:       elru = {1'b0, lr[1], 1'b1};
      default: elru = {1'b0, lr[1], 1'b0};
    endcase
    elat = 3 + (ewb ? dwb + 1 : 0) + (eh ? 0 : dfl + 1);

    @(negedge clk);
    check("ready", 32'(pe_ready), 1);
    pe_req = 1'b1; pe_wr = w; pe_tag = t; way_hit = wh; fill_or_victim_way = vic;
    req_clean = cl; lru_in = lr; mem_ack = 1'b0;
    @(posedge clk);
    #1;
    pe_req = 1'b0; pe_wr = 1'($urandom); pe_tag = TW'($urandom);
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
      if (mem_wr_req) begin wbc++; mem_ack = (wbc == dwb + 1); end
      else if (mem_rd_req) begin flc++; mem_ack = (flc == dfl + 1); end
      else mem_ack = 1'($urandom_range(0, 1));
      #1;
      if (arr_rd) arr_n = n;
      if (pe_access) acc_n = n;
      if (tag_we) begin
        tagc++;
        check("fill_way_sel", 32'(way_sel), 32'(ew));
        check("fill_val_we", 32'(val_we), 1);
        check("fill_tag_q", 32'(pe_tag_q), 32'(t));
      end
      if (pe_done) begin
        done = 1;
        check("latency", n, elat);
        check("pe_hit", 32'(pe_hit), 32'(eh));
        check("lru_we", 32'(lru_we), 1);
        check("lru_wdata", 32'(lru_wdata), 32'(elru));
        check("upd_way_sel", 32'(way_sel), 32'(ew));
        check("mod_we", 32'(mod_we), 32'(w || !eh));
        if (w || !eh) check("mod_wdata", 32'(mod_wdata), 32'(w));
      end
    end
    mem_ack = 1'b0;
    if (!done) check("done_timeout", 0, 1);
    check("arr_rd_cycle", arr_n, 1);
    check("access_cycle", acc_n, 2);
    check("wb_cycles", wbc, ewb ? dwb + 1 : 0);
    check("fill_cycles", flc, eh ? 0 : dfl + 1);
    check("tag_we_count", tagc, eh ? 0 : 1);
    @(negedge clk);
    #1;
    check_stats();
    $display("txn %0d wr=%0b tag=%0h way_hit=%b victim=%b clean=%0b lru=%b hit=%0b lat=%0d",
             txn_no, w, t, wh, vic, cl, lr, eh, n);
  endtask

  initial begin
    logic [3:0] wh, vic;
    int r, k;
    bit seen;
    rst_n = 1'b0; pe_req = 1'b1; pe_wr = 1'b0; pe_tag = '0; way_hit = '0;
    fill_or_victim_way = 4'b0001; req_clean = 1'b1; lru_in = '0; mem_ack = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_ready", 32'(pe_ready), 0);
    check("rst_outputs", {arr_rd, pe_access, pe_done, mem_wr_req, mem_rd_req,
                          tag_we, val_we, mod_we, lru_we, way_sel}, 0);
    check_stats();
    rst_n = 1'b1;
    #1;
    check("ready_after_rst", 32'(pe_ready), 1);
    check_stats();
    pe_req = 1'b0;

    do_txn(1'b0, 14'h1234, 4'b0100, 4'b0001, 1'b1, 3'b000, 0, 0);
    do_txn(1'b1, 14'h0abc, 4'b0000, 4'b0001, 1'b1, 3'b010, 0, 3);
    do_txn(1'b0, 14'h3fff, 4'b0000, 4'b1000, 1'b0, 3'b001, 0, 1);
    do_txn(1'b0, 14'h0555, 4'b0110, 4'b0001, 1'b1, 3'b111, 0, 0);

    for (int i = 0; i < 50; i++) begin
      r = $urandom_range(0, 9);
      if (r < 5)      wh = 4'd0;
      else if (r < 9) wh = 4'b0001 << $urandom_range(0, 3);
      else            wh = 4'($urandom_range(1, 15));
      vic = 4'b0001 << $urandom_range(0, 3);
      do_txn(1'($urandom), TW'($urandom), wh, vic, 1'($urandom), 3'($urandom),
             $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // Abandon a transaction in the middle of its line fill.
    txn_no++;
    @(negedge clk);
    pe_req = 1'b1; pe_wr = 1'b1; way_hit = 4'd0; fill_or_victim_way = 4'b0010;
    req_clean = 1'b1; mem_ack = 1'b0;
    @(posedge clk);
    #1;
    pe_req = 1'b0;
    seen = 0; k = 0;
    while (!seen && k < 10) begin
      @(negedge clk);
      k++;
      if (mem_rd_req) seen = 1;
    end
    check("fill_reached", 32'(seen), 1);
    rst_n = 1'b0;
    #1;
    check("rst_drops_rd_req", 32'(mem_rd_req), 0);
    check("rst_no_done", 32'(pe_done), 0);
    m_hits = 0; m_miss = 0; m_wb = 0; m_err = 1'b0;
    check_stats();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ready_after_rst2", 32'(pe_ready), 1);
    check("no_done_after_rst", 32'(pe_done), 0);
    $display("txn %0d reset during fill", txn_no);

    for (int i = 0; i < 6; i++) begin
      wh = ($urandom_range(0, 1) == 1) ? 4'b0001 << $urandom_range(0, 3) : 4'd0;
      do_txn(1'($urandom), TW'($urandom), wh, 4'b0001 << $urandom_range(0, 3),
             1'($urandom), 3'($urandom), $urandom_range(0, 2), $urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
